// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage_pkg / mem_stage
//
// Memory-access pipeline stage of the MINAv2 core (EX -> MEM -> WB).
// Non-memory instructions pass straight through with one cycle of latency.
// Word loads and stores are issued on a request/grant/response bus; the
// upstream pipeline is stalled while a bus transaction is outstanding.
//
// Optional build macro: MEM_TIMEOUT_EN
//   When defined, a transaction that stays in REQ+WAIT for TIMEOUT_CYCLES
//   cycles is aborted: err_o pulses and a load writes back ERR_DATA.
//   When undefined, the stage waits indefinitely and err_o is always 0.
//
// Ports:
//   clk, rst_n      core clock, asynchronous active-low reset
//   valid_i         params_i holds a valid instruction
//   params_i        rd_addr, rd_data (ALU result / address), mem_op, mem_data
//   stall_o         upstream must hold params_i/valid_i this cycle (comb)
//   wb_valid_o      wb_params_o valid (registered)
//   wb_params_o     rd_addr, rd_data to WB (registered)
//   bus_req_o       bus request (registered)
//   bus_we_o        1 = store
//   bus_addr_o      word-aligned bus address
//   bus_wdata_o     store data
//   bus_wrstb_o     byte strobes (all set for a store, clear for a load)
//   bus_gnt_i       request accepted this cycle
//   bus_rvalid_i    load response valid
//   bus_rdata_i     load data
//   err_o           one-cycle abort pulse (registered)
// -----------------------------------------------------------------------------

package mem_stage_pkg;
  typedef logic [31:0] u32_t;
  typedef logic [3:0]  wrstb_t;
  typedef logic [4:0]  reg_addr_t;
  typedef logic [1:0]  mem_op_t;

  localparam mem_op_t MEM_OP_NONE  = 2'b00;
  localparam mem_op_t MEM_OP_LOAD  = 2'b01;
  localparam mem_op_t MEM_OP_STORE = 2'b10;

  typedef struct packed {
    reg_addr_t rd_addr;
    u32_t      rd_data;
    mem_op_t   mem_op;
    u32_t      mem_data;
  } mem_params_t;

  typedef struct packed {
    reg_addr_t rd_addr;
    u32_t      rd_data;
  } wb_params_t;
endpackage

module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int   TIMEOUT_CYCLES = 256,
  parameter u32_t ERR_DATA       = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_i,
  input  mem_params_t params_i,
  output logic        stall_o,
  output logic        wb_valid_o,
  output wb_params_t  wb_params_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output u32_t        bus_addr_o,
  output u32_t        bus_wdata_o,
  output wrstb_t      bus_wrstb_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  u32_t        bus_rdata_i,
  output logic        err_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10
  } state_t;

  state_t     state_q, state_d;
  logic       wb_valid_q, wb_valid_d;
  wb_params_t wb_params_q, wb_params_d;
  logic       bus_req_q, bus_req_d;
  logic       bus_we_q, bus_we_d;
  u32_t       bus_addr_q, bus_addr_d;
  u32_t       bus_wdata_q, bus_wdata_d;
  wrstb_t     bus_wrstb_q, bus_wrstb_d;
  logic       err_q, err_d;
  reg_addr_t  rd_addr_q, rd_addr_d;
  logic       stall_s;
  logic       is_mem_op_s;
  logic       timeout_s;

  assign is_mem_op_s = (params_i.mem_op == MEM_OP_LOAD) || (params_i.mem_op == MEM_OP_STORE);

`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Cycle counter: held at zero in IDLE so it starts from zero on REQ entry.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_IDLE) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Cycle counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Asserted in the last allowed REQ/WAIT cycle.
  assign timeout_s = (cnt_q == TO_LAST);
`else
  // Timeout parameters only matter in the timeout build.
  logic unused_timeout_cfg_s;
  assign unused_timeout_cfg_s = (TIMEOUT_CYCLES == 32'sd0);
  assign timeout_s = 1'b0;
`endif

  // Next-state, bus and writeback decode.
  always_comb begin
    state_d     = state_q;
    stall_s     = 1'b0;
    wb_valid_d  = 1'b0;
    wb_params_d = wb_params_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_wrstb_d = bus_wrstb_q;
    err_d       = 1'b0;
    rd_addr_d   = rd_addr_q;

    case (state_q)
      ST_IDLE: begin
        if (valid_i && is_mem_op_s) begin
          stall_s     = 1'b1;
          rd_addr_d   = params_i.rd_addr;
          bus_req_d   = 1'b1;
          bus_we_d    = (params_i.mem_op == MEM_OP_STORE);
          bus_addr_d  = {params_i.rd_data[31:2], 2'b00};
          bus_wdata_d = params_i.mem_data;
          bus_wrstb_d = (params_i.mem_op == MEM_OP_STORE) ? 4'b1111 : 4'b0000;
          state_d     = ST_REQ;
        end else if (valid_i) begin
          // NONE and the reserved encoding are plain ALU passthrough.
          wb_valid_d          = 1'b1;
          wb_params_d.rd_addr = params_i.rd_addr;
          wb_params_d.rd_data = params_i.rd_data;
        end else begin
          wb_valid_d = 1'b0;
        end
      end

      ST_REQ: begin
        if (bus_gnt_i) begin
          // A response arriving with the grant is not valid; WAIT ignores it.
          bus_req_d = 1'b0;
          if (bus_we_q) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_WAIT;
            stall_s = 1'b1;
          end
        end else if (timeout_s) begin
          bus_req_d = 1'b0;
          err_d     = 1'b1;
          state_d   = ST_IDLE;
          if (!bus_we_q) begin
            wb_valid_d          = 1'b1;
            wb_params_d.rd_addr = rd_addr_q;
            wb_params_d.rd_data = ERR_DATA;
          end else begin
            wb_valid_d = 1'b0;
          end
        end else begin
          stall_s = 1'b1;
        end
      end

      ST_WAIT: begin
        if (bus_rvalid_i) begin
          state_d             = ST_IDLE;
          wb_valid_d          = 1'b1;
          wb_params_d.rd_addr = rd_addr_q;
          wb_params_d.rd_data = bus_rdata_i;
        end else if (timeout_s) begin
          err_d               = 1'b1;
          state_d             = ST_IDLE;
          wb_valid_d          = 1'b1;
          wb_params_d.rd_addr = rd_addr_q;
          wb_params_d.rd_data = ERR_DATA;
        end else begin
          stall_s = 1'b1;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        bus_req_d = 1'b0;
      end
    endcase
  end

  // Pipeline state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      wb_valid_q  <= 1'b0;
      wb_params_q <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'h0000_0000;
      bus_wdata_q <= 32'h0000_0000;
      bus_wrstb_q <= 4'b0000;
      err_q       <= 1'b0;
      rd_addr_q   <= 5'd0;
    end else begin
      state_q     <= state_d;
      wb_valid_q  <= wb_valid_d;
      wb_params_q <= wb_params_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_wrstb_q <= bus_wrstb_d;
      err_q       <= err_d;
      rd_addr_q   <= rd_addr_d;
    end
  end

  assign stall_o     = stall_s;
  assign wb_valid_o  = wb_valid_q;
  assign wb_params_o = wb_params_q;
  assign bus_req_o   = bus_req_q;
  assign bus_we_o    = bus_we_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_wdata_o = bus_wdata_q;
  assign bus_wrstb_o = bus_wrstb_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage: directed self-checking bench for mem_stage.
// Inputs change 1 ns after a rising edge; registered outputs are sampled there
// and the combinational stall_o 1 ns later, after new inputs settle.
// -----------------------------------------------------------------------------
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        valid_i;
  mem_params_t params_i;
  logic        stall_o;
  logic        wb_valid_o;
  wb_params_t  wb_params_o;
  logic        bus_req_o;
  logic        bus_we_o;
  u32_t        bus_addr_o;
  u32_t        bus_wdata_o;
  wrstb_t      bus_wrstb_o;
  logic        bus_gnt_i;
  logic        bus_rvalid_i;
  u32_t        bus_rdata_i;
  logic        err_o;

  int total;
  int bad;

  mem_stage #(.TIMEOUT_CYCLES(4), .ERR_DATA(32'hDEADBEEF)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .params_i(params_i),
    .stall_o(stall_o), .wb_valid_o(wb_valid_o), .wb_params_o(wb_params_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_wrstb_o(bus_wrstb_o), .bus_gnt_i(bus_gnt_i),
    .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i), .err_o(err_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input mem_op_t op, input reg_addr_t rda,
                       input u32_t rdd, input u32_t md);
    valid_i           = v;
    params_i.mem_op   = op;
    params_i.rd_addr  = rda;
    params_i.rd_data  = rdd;
    params_i.mem_data = md;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = 32'h0;
    drive(1'b0, MEM_OP_NONE, 5'd0, 32'h0, 32'h0);
    #2;
    total++; if (wb_valid_o !== 1'b0) begin bad++; $display("FAIL rst_wb_valid got=%0h want=0", wb_valid_o); end
    total++; if (wb_params_o !== 37'h0) begin bad++; $display("FAIL rst_wb_params got=%0h want=0", wb_params_o); end
    total++; if ({bus_req_o, bus_we_o, bus_wrstb_o, err_o} !== 7'h0) begin bad++; $display("FAIL rst_ctrl got=%0h want=0", {bus_req_o, bus_we_o, bus_wrstb_o, err_o}); end
    total++; if ({bus_addr_o, bus_wdata_o} !== 64'h0) begin bad++; $display("FAIL rst_bus got=%0h want=0", {bus_addr_o, bus_wdata_o}); end
    total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL rst_stall got=%0h want=0", stall_o); end
    tick; tick;
    @(negedge clk); rst_n = 1'b1;
    tick;
  endtask

  task automatic test_passthrough;
    drive(1'b1, MEM_OP_NONE, 5'd5, 32'h1234, 32'h0);
    #1;
    total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL pt_stall got=%0h want=0", stall_o); end
    tick;
    total++; if (wb_valid_o !== 1'b1) begin bad++; $display("FAIL pt_wb_valid got=%0h want=1", wb_valid_o); end
    total++; if (wb_params_o !== {5'd5, 32'h1234}) begin bad++; $display("FAIL pt_wb_params got=%0h want=%0h", wb_params_o, {5'd5, 32'h1234}); end
    drive(1'b1, 2'b11, 5'd9, 32'h55, 32'h0);
    #1;
    total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL rsv_stall got=%0h want=0", stall_o); end
    tick;
    total++; if (wb_params_o !== {5'd9, 32'h55} || wb_valid_o !== 1'b1) begin bad++; $display("FAIL rsv_wb got=%0h/%0h want=1/%0h", wb_valid_o, wb_params_o, {5'd9, 32'h55}); end
    drive(1'b0, MEM_OP_NONE, 5'd0, 32'h0, 32'h0);
    tick;
    total++; if (wb_valid_o !== 1'b0) begin bad++; $display("FAIL bubble_wb_valid got=%0h want=0", wb_valid_o); end
  endtask

  task automatic test_store;
    drive(1'b1, MEM_OP_STORE, 5'd3, 32'h103, 32'hCAFEF00D);
    #1;
    total++; if (stall_o !== 1'b1) begin bad++; $display("FAIL st_idle_stall got=%0h want=1", stall_o); end
    for (int c = 0; c < 2; c++) begin
      tick;
      total++; if (bus_req_o !== 1'b1 || bus_we_o !== 1'b1) begin bad++; $display("FAIL st_req_we c%0d got=%0h%0h want=11", c, bus_req_o, bus_we_o); end
      total++; if (bus_addr_o !== 32'h100) begin bad++; $display("FAIL st_addr c%0d got=%0h want=100", c, bus_addr_o); end
      total++; if (bus_wdata_o !== 32'hCAFEF00D || bus_wrstb_o !== 4'hF) begin bad++; $display("FAIL st_data c%0d got=%0h/%0h want=cafef00d/f", c, bus_wdata_o, bus_wrstb_o); end
      total++; if (stall_o !== 1'b1 || wb_valid_o !== 1'b0) begin bad++; $display("FAIL st_wait c%0d stall/wbv got=%0h%0h want=10", c, stall_o, wb_valid_o); end
    end
    tick;
    bus_gnt_i = 1'b1;
    #1;
    total++; if (stall_o !== 1'b0 || bus_req_o !== 1'b1) begin bad++; $display("FAIL st_gnt stall/req got=%0h%0h want=01", stall_o, bus_req_o); end
    tick;
    bus_gnt_i = 1'b0;
    drive(1'b0, MEM_OP_NONE, 5'd0, 32'h0, 32'h0);
    total++; if (bus_req_o !== 1'b0 || wb_valid_o !== 1'b0) begin bad++; $display("FAIL st_done req/wbv got=%0h%0h want=00", bus_req_o, wb_valid_o); end
    tick;
    total++; if (wb_valid_o !== 1'b0) begin bad++; $display("FAIL st_no_wb got=%0h want=0", wb_valid_o); end
  endtask

  task automatic test_load;
    drive(1'b1, MEM_OP_LOAD, 5'd7, 32'h200, 32'h0);
    #1;
    total++; if (stall_o !== 1'b1) begin bad++; $display("FAIL ld_idle_stall got=%0h want=1", stall_o); end
    tick;
    total++; if (bus_req_o !== 1'b1 || bus_we_o !== 1'b0 || bus_wrstb_o !== 4'h0) begin bad++; $display("FAIL ld_req got=%0h%0h%0h want=100", bus_req_o, bus_we_o, bus_wrstb_o); end
    total++; if (bus_addr_o !== 32'h200) begin bad++; $display("FAIL ld_addr got=%0h want=200", bus_addr_o); end
    bus_gnt_i = 1'b1; bus_rvalid_i = 1'b1; bus_rdata_i = 32'hFFFF0000;
    #1;
    total++; if (stall_o !== 1'b1) begin bad++; $display("FAIL ld_gnt_stall got=%0h want=1", stall_o); end
    tick;
    bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0;
    #1;
    total++; if (bus_req_o !== 1'b0 || wb_valid_o !== 1'b0 || stall_o !== 1'b1) begin bad++; $display("FAIL ld_wait1 req/wbv/stall got=%0h%0h%0h want=001", bus_req_o, wb_valid_o, stall_o); end
    tick;
    total++; if (stall_o !== 1'b1) begin bad++; $display("FAIL ld_wait2_stall got=%0h want=1", stall_o); end
    tick;
    bus_rvalid_i = 1'b1; bus_rdata_i = 32'hA5A5A5A5;
    #1;
    total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL ld_rvalid_stall got=%0h want=0", stall_o); end
    tick;
    bus_rvalid_i = 1'b0;
    drive(1'b0, MEM_OP_NONE, 5'd0, 32'h0, 32'h0);
    total++; if (wb_valid_o !== 1'b1 || wb_params_o !== {5'd7, 32'hA5A5A5A5}) begin bad++; $display("FAIL ld_wb got=%0h/%0h want=1/%0h", wb_valid_o, wb_params_o, {5'd7, 32'hA5A5A5A5}); end
    tick;
  endtask

  task automatic test_back_to_back;
    bus_gnt_i = 1'b1; bus_rvalid_i = 1'b1; bus_rdata_i = 32'h1;
    #1;
    total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL spur_stall got=%0h want=0", stall_o); end
    tick;
    total++; if (bus_req_o !== 1'b0 || wb_valid_o !== 1'b0) begin bad++; $display("FAIL spur_effect req/wbv got=%0h%0h want=00", bus_req_o, wb_valid_o); end
    bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0;
    drive(1'b1, MEM_OP_LOAD, 5'd2, 32'h47, 32'h0);
    tick;
    total++; if (bus_addr_o !== 32'h44) begin bad++; $display("FAIL b2b_addr got=%0h want=44", bus_addr_o); end
    bus_gnt_i = 1'b1;
    tick;
    bus_gnt_i = 1'b0;
    bus_rvalid_i = 1'b1; bus_rdata_i = 32'h11223344;
    #1;
    total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL b2b_rv_stall got=%0h want=0", stall_o); end
    tick;
    bus_rvalid_i = 1'b0;
    drive(1'b1, MEM_OP_NONE, 5'd4, 32'h77, 32'h0);
    total++; if (wb_valid_o !== 1'b1 || wb_params_o !== {5'd2, 32'h11223344}) begin bad++; $display("FAIL b2b_ld_wb got=%0h/%0h want=1/%0h", wb_valid_o, wb_params_o, {5'd2, 32'h11223344}); end
    #1;
    total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL b2b_none_stall got=%0h want=0", stall_o); end
    tick;
    drive(1'b0, MEM_OP_NONE, 5'd0, 32'h0, 32'h0);
    total++; if (wb_valid_o !== 1'b1 || wb_params_o !== {5'd4, 32'h77}) begin bad++; $display("FAIL b2b_none_wb got=%0h/%0h want=1/%0h", wb_valid_o, wb_params_o, {5'd4, 32'h77}); end
    tick;
  endtask

  task automatic test_reset_mid;
    drive(1'b1, MEM_OP_LOAD, 5'd9, 32'h300, 32'h0);
    tick;
    bus_gnt_i = 1'b1;
    tick;
    bus_gnt_i = 1'b0;
    tick;
    #2;
    rst_n = 1'b0;
    drive(1'b0, MEM_OP_NONE, 5'd0, 32'h0, 32'h0);
    #1;
    total++; if (bus_req_o !== 1'b0 || bus_addr_o !== 32'h0) begin bad++; $display("FAIL rmid_bus got=%0h/%0h want=0/0", bus_req_o, bus_addr_o); end
    total++; if (wb_valid_o !== 1'b0 || wb_params_o !== 37'h0 || err_o !== 1'b0) begin bad++; $display("FAIL rmid_wb got=%0h/%0h/%0h want=0/0/0", wb_valid_o, wb_params_o, err_o); end
    total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL rmid_stall got=%0h want=0", stall_o); end
    @(negedge clk); rst_n = 1'b1;
    tick;
    drive(1'b1, MEM_OP_NONE, 5'd6, 32'h99, 32'h0);
    tick;
    drive(1'b0, MEM_OP_NONE, 5'd0, 32'h0, 32'h0);
    total++; if (wb_valid_o !== 1'b1 || wb_params_o !== {5'd6, 32'h99}) begin bad++; $display("FAIL rmid_after got=%0h/%0h want=1/%0h", wb_valid_o, wb_params_o, {5'd6, 32'h99}); end
    tick;
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout;
    drive(1'b1, MEM_OP_LOAD, 5'd12, 32'h400, 32'h0);
    for (int c = 1; c <= 3; c++) begin
      tick;
      total++; if (stall_o !== 1'b1 || bus_req_o !== 1'b1) begin bad++; $display("FAIL to_req c%0d stall/req got=%0h%0h want=11", c, stall_o, bus_req_o); end
    end
    tick;
    total++; if (stall_o !== 1'b0 || err_o !== 1'b0) begin bad++; $display("FAIL to_last stall/err got=%0h%0h want=00", stall_o, err_o); end
    tick;
    drive(1'b0, MEM_OP_NONE, 5'd0, 32'h0, 32'h0);
    total++; if (err_o !== 1'b1 || bus_req_o !== 1'b0) begin bad++; $display("FAIL to_err err/req got=%0h%0h want=10", err_o, bus_req_o); end
    total++; if (wb_valid_o !== 1'b1 || wb_params_o !== {5'd12, 32'hDEADBEEF}) begin bad++; $display("FAIL to_wb got=%0h/%0h want=1/%0h", wb_valid_o, wb_params_o, {5'd12, 32'hDEADBEEF}); end
    tick;
    total++; if (err_o !== 1'b0) begin bad++; $display("FAIL to_pulse got=%0h want=0", err_o); end
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    test_reset;
    test_passthrough;
    test_store;
    test_load;
    test_back_to_back;
    test_reset_mid;
`ifdef MEM_TIMEOUT_EN
    test_timeout;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
